seg7_scan_driver: RTL
=====================

SEG7_SCAN_DRIVER -- requirements
Module: seg7_scan_driver

Interface
REQ-001 SHALL have parameter NUM_DIGITS, default 8, number of multiplexed digits, legal range 1..8.
REQ-002 SHALL have parameter PRESCALE, default 1024, Clkpin cycles per scan tick, legal range >= 1.
REQ-003 SHALL use one clock; reset is synchronous and active-high.
REQ-004 SHALL have port Clkpin  input  1  system clock; all state changes on its rising edge.
REQ-005 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port SegData  input  7*NUM_DIGITS  active-low segment codes; digit i occupies bits [7i+6:7i].
REQ-007 SHALL have port DpData  input  NUM_DIGITS  active-low decimal point per digit.
REQ-008 SHALL have port DigitEnable  input  NUM_DIGITS  1 = digit may light, 0 = digit forced dark.
REQ-009 SHALL have port Brightness  input  4  on-phases per digit slot; 0 = dark, 15 = maximum.
REQ-010 SHALL have port Anode  output  NUM_DIGITS  active-low digit select; at most one bit low.
REQ-011 SHALL have port SevenSegmentChar  output  7  active-low segments of the lit digit.
REQ-012 SHALL have port DecimalPoint  output  1  active-low decimal point of the lit digit.
REQ-013 SHALL have port FrameStart  output  1  one-cycle pulse when a new input snapshot is taken.

Function
REQ-014 SHALL run a prescaler counting 0..PRESCALE-1 and assert an internal tick in the cycle the count equals PRESCALE-1, wrapping to 0 on the next edge; PRESCALE=1 gives a tick every cycle.
REQ-015 SHALL hold a phase counter 0..15 and a digit index 0..NUM_DIGITS-1; both advance only on tick.
REQ-016 On tick, phase SHALL increment; when phase is 15, it SHALL wrap to 0 and the digit index SHALL increment, wrapping from NUM_DIGITS-1 to 0.
REQ-017 One slot = 16 ticks; one frame = NUM_DIGITS slots = 16*NUM_DIGITS*PRESCALE cycles.
REQ-018 Phase 0 of every slot SHALL be a blanking guard: all Anode bits 1, SevenSegmentChar 7'h7F, DecimalPoint 1.
REQ-019 The lit digit d SHALL have Anode[d]=0 exactly when 1 <= phase <= snapshot brightness and snapshot enable[d]=1; otherwise all Anode bits SHALL be 1.
REQ-020 While Anode[d]=0, SevenSegmentChar SHALL equal the snapshot SegData of digit d and DecimalPoint the snapshot DpData[d]; otherwise SevenSegmentChar SHALL be 7'h7F and DecimalPoint 1.
REQ-021 SegData, DpData, DigitEnable and Brightness SHALL be captured into snapshot registers on the tick where digit index = 0 and phase = 0; input changes at any other time SHALL NOT be visible until the next capture.
REQ-022 FrameStart SHALL be 1 in exactly the cycle of the capture tick.
REQ-023 All outputs SHALL be functions of registered state only, with no combinational path from inputs.
REQ-024 Digits shall be scanned in ascending index order, digit 0 being the rightmost.

Reset
REQ-025 While reset is sampled high: prescaler 0, phase 0, digit index 0, snapshot SegData all 7'h7F, DpData all 1, DigitEnable 0, Brightness 0.
REQ-026 Outputs during and after reset until the first capture SHALL be Anode all 1, SevenSegmentChar 7'h7F, DecimalPoint 1, FrameStart 0.
REQ-027 Reset asserted mid-frame SHALL abandon the frame; the first capture after reset release SHALL occur PRESCALE cycles after release.

Structure
REQ-028 A shared package seg7_pkg SHALL hold SEG_BLANK (7'h7F), PHASES_PER_SLOT (16) and the phase/brightness width (4).
REQ-029 The prescaler SHALL be one sub-module, seg7_tick_gen, parametrised by PRESCALE, outputting the single-cycle tick.

Verification (NUM_DIGITS=4, PRESCALE=2)
REQ-030 Reset held 10 cycles, then released -> Anode 4'hF, SevenSegmentChar 7'h7F throughout reset; FrameStart high only in cycle 2 after release.
REQ-031 SegData digits {0:7'h40, 1:7'h79, 2:7'h24, 3:7'h30}, DigitEnable 4'hF, Brightness 15 -> Anode 4'b1110 with 7'h40 for 30 cycles, then 2 cycles blank, then 4'b1101 with 7'h79, and so on through digit 3.
REQ-032 Brightness 4 -> each digit lit 8 cycles (phases 1..4), dark 24 cycles per 32-cycle slot.
REQ-033 Brightness 0 or DigitEnable 4'h0 -> Anode 4'hF for a full 128-cycle frame; DigitEnable 4'b0101 -> only digits 0 and 2 light, slot timing unchanged.
REQ-034 SegData digit 0 changed mid-frame -> old code displayed until next FrameStart, new code from the following digit-0 slot; reset asserted mid-slot -> blank outputs next cycle, scan restarts at digit 0.

Source files
------------

// File: rtl/seg7_pkg.sv
// Shared constants and types for the seven-segment scan driver.
package seg7_pkg;

  // All segments off (segments are active-low).
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // Ticks per digit slot; phase 0 of each slot is the blanking guard.
  localparam int PHASES_PER_SLOT = 16;

  // Width of the phase counter and of the brightness setting.
  localparam int PHASE_W = 4;

  // Width of the digit index (enough for up to 8 digits).
  localparam int DIG_W = 3;

  typedef logic [PHASE_W-1:0] phase_t;
  typedef logic [DIG_W-1:0]   digit_t;

  // Segment and decimal-point drive for the currently lit digit.
  typedef struct packed {
    logic [6:0] seg;
    logic       dp;
  } seg_drive_t;

  // A phase lights the digit when it is past the guard phase and
  // not beyond the requested brightness.
  function automatic logic phase_is_lit(input phase_t phase, input phase_t bright);
    return (phase != '0) && (phase <= bright);
  endfunction

endpackage

// File: rtl/seg7_scan_driver_if.sv
// Display-side bundle of the scan driver: digit data in, multiplexed drive out.
//
// Transfer semantics: there is no valid/ready pair. The host holds
// SegData/DpData/DigitEnable/Brightness steady; the driver samples all of
// them together in the single cycle FrameStart is high, and that snapshot
// is what gets displayed for the whole following frame. A host that wants
// a tear-free update changes its data in the cycle after FrameStart.
interface seg7_scan_driver_if #(
  parameter int NUM_DIGITS = 8
);
  import seg7_pkg::*;

  logic [7*NUM_DIGITS-1:0] SegData;
  logic [NUM_DIGITS-1:0]   DpData;
  logic [NUM_DIGITS-1:0]   DigitEnable;
  logic [PHASE_W-1:0]      Brightness;
  logic [NUM_DIGITS-1:0]   Anode;
  logic [6:0]              SevenSegmentChar;
  logic                    DecimalPoint;
  logic                    FrameStart;

  // Host side: supplies digit data, observes the display drive.
  modport master (
    output SegData, DpData, DigitEnable, Brightness,
    input  Anode, SevenSegmentChar, DecimalPoint, FrameStart
  );

  // Driver side: consumes digit data, produces the display drive.
  modport slave (
    input  SegData, DpData, DigitEnable, Brightness,
    output Anode, SevenSegmentChar, DecimalPoint, FrameStart
  );

endinterface

// File: rtl/seg7_tick_gen.sv
// Prescaler: counts 0..PRESCALE-1 and flags the last count as a one-cycle tick.
module seg7_tick_gen #(
  parameter int PRESCALE = 1024
) (
  input  logic Clkpin,
  input  logic reset,
  output logic tick
);

  // A one-bit counter is kept even for PRESCALE=1 so the logic stays regular;
  // with LAST_COUNT = 0 the tick is then simply asserted every cycle.
  localparam int CNT_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [CNT_W-1:0] LAST_COUNT = CNT_W'(PRESCALE - 1);

  logic [CNT_W-1:0] count;

  // Free-running modulo-PRESCALE counter, restarted by reset.
  always_ff @(posedge Clkpin) begin
    if (reset) begin
      count <= '0;
    end else if (count == LAST_COUNT) begin
      count <= '0;
    end else begin
      count <= count + CNT_W'(1);
    end
  end

  assign tick = (count == LAST_COUNT);

endmodule

// File: rtl/seg7_scan_driver.sv
// Multiplexed seven-segment scan driver with per-frame input snapshot and
// 16-step brightness (PWM by phase within each digit slot).
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS = 8,
  parameter int PRESCALE   = 1024
) (
  input  logic                    Clkpin,
  input  logic                    reset,
  input  logic [7*NUM_DIGITS-1:0] SegData,
  input  logic [NUM_DIGITS-1:0]   DpData,
  input  logic [NUM_DIGITS-1:0]   DigitEnable,
  input  logic [PHASE_W-1:0]      Brightness,
  output logic [NUM_DIGITS-1:0]   Anode,
  output logic [6:0]              SevenSegmentChar,
  output logic                    DecimalPoint,
  output logic                    FrameStart
);

  localparam digit_t LAST_DIGIT = digit_t'(NUM_DIGITS - 1);
  localparam phase_t LAST_PHASE = phase_t'(PHASES_PER_SLOT - 1);

  logic   tick;
  logic   capture;
  phase_t phase;
  digit_t digit;

  // Snapshot of the host data, refreshed once per frame.
  logic [7*NUM_DIGITS-1:0] snap_seg;
  logic [NUM_DIGITS-1:0]   snap_dp;
  logic [NUM_DIGITS-1:0]   snap_en;
  phase_t                  snap_bright;

  // Output selection helpers.
  logic       lit_phase;
  seg_drive_t lit_drv;

  seg7_tick_gen #(
    .PRESCALE(PRESCALE)
  ) u_tick_gen (
    .Clkpin(Clkpin),
    .reset (reset),
    .tick  (tick)
  );

  // The snapshot is taken on the tick that ends the guard phase of digit 0,
  // so a fresh snapshot is in place before digit 0 first lights.
  assign capture    = tick && (digit == '0) && (phase == '0);
  assign FrameStart = capture;

  // Phase advances every tick; digit index advances when the phase wraps.
  always_ff @(posedge Clkpin) begin
    if (reset) begin
      phase <= '0;
      digit <= '0;
    end else if (tick) begin
      if (phase == LAST_PHASE) begin
        phase <= '0;
        digit <= (digit == LAST_DIGIT) ? '0 : digit + digit_t'(1);
      end else begin
        phase <= phase + phase_t'(1);
      end
    end
  end

  // Capture all host inputs together at frame start; reset leaves the display dark.
  always_ff @(posedge Clkpin) begin
    if (reset) begin
      snap_seg    <= {NUM_DIGITS{SEG_BLANK}};
      snap_dp     <= '1;
      snap_en     <= '0;
      snap_bright <= '0;
    end else if (capture) begin
      snap_seg    <= SegData;
      snap_dp     <= DpData;
      snap_en     <= DigitEnable;
      snap_bright <= Brightness;
    end
  end

  // Drive the current digit from registered state only; blank in every
  // guard phase, beyond the brightness setting, or for a disabled digit.
  always_comb begin
    Anode       = '1;
    lit_drv.seg = SEG_BLANK;
    lit_drv.dp  = 1'b1;
    lit_phase   = phase_is_lit(phase, snap_bright);
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (lit_phase && snap_en[i] && (digit == digit_t'(i))) begin
        Anode[i]    = 1'b0;
        lit_drv.seg = snap_seg[7*i +: 7];
        lit_drv.dp  = snap_dp[i];
      end
    end
    SevenSegmentChar = lit_drv.seg;
    DecimalPoint     = lit_drv.dp;
  end

endmodule
